// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the parametrised register file.
package regfile_pkg;
  typedef enum logic {IDLE = 1'b0, CLEARING = 1'b1} rf_state_t;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 4;
  localparam int RF_NUM_RD = 2;
endpackage

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer: walks every entry once, one per cycle, while busy is high.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              clr_req,
  output logic              busy,
  output logic              clear_we,
  output logic [ADDR_W-1:0] clear_addr
);

  rf_state_t         state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Exit happens on the cycle that wipes the last entry, so the pointer never wraps.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEARING;
          ptr_nxt   = '0;
        end
      end
      CLEARING: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == {ADDR_W{1'b1}}) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        ptr_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    busy       = (state == CLEARING);
    clear_we   = (state == CLEARING);
    clear_addr = ptr;
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised 1W/2R register file with registered reads, write bypass and bulk clear.
// Build option: REGFILE_R0_ZERO_EN hardwires entry 0 to zero.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid,
  input  logic              clr_req,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  logic                                 clear_we;
  logic [ADDR_W-1:0]                    clear_addr;
  logic                                 wr_fire, rd_fire;
  logic [RF_NUM_RD-1:0][ADDR_W-1:0]     rd_addr;
  logic [RF_NUM_RD-1:0][DATA_W-1:0]     rd_mux, rd_q;

  regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .clk        (clk),
    .clr        (clr),
    .clr_req    (clr_req),
    .busy       (busy),
    .clear_we   (clear_we),
    .clear_addr (clear_addr)
  );

  // A clear request in the same cycle drops the write; reads still see pre-clear data.
  assign wr_fire = wr_en && !busy && !clr_req && !(R0_ZERO && wr_addr == '0);
  assign rd_fire = rd_en && !busy;

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  always_comb begin
    for (int p = 0; p < RF_NUM_RD; p++) begin
      rd_mux[p] = mem[rd_addr[p]];
      if (wr_fire && rd_addr[p] == wr_addr) rd_mux[p] = wr_data;
      if (R0_ZERO && rd_addr[p] == '0) rd_mux[p] = '0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear_we) begin
      mem[clear_addr] <= '0;
    end else if (wr_fire) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rd_q     <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) rd_q <= rd_mux;
    end
  end

  assign rd_data_a = rd_q[0];
  assign rd_data_b = rd_q[1];

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed table, clear/reset sequences, random vs model.
module tb_regfile_param;

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0 = 1'b1;
`else
  localparam bit R0 = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0, clr_req = 1'b0;
  logic [3:0]  wr_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid, busy;

  int checks = 0;
  int failures = 0;

  // Reference model: the whole array is wiped when a clear is accepted; the DUT
  // ignores all traffic while busy, so only the busy cycle count matters afterwards.
  logic [31:0] m_mem [16];
  int          busy_left;
  logic [31:0] m_a, m_b;
  logic        m_v;

  always #5 clk = ~clk;

  regfile_param dut (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid(rd_valid),
    .clr_req(clr_req), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    busy_left = 0;
    m_a = '0; m_b = '0; m_v = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a, input bit wr_eff,
                                         input logic [3:0] wa, input logic [31:0] wd);
    if (R0 && a == 4'd0) return 32'h0;
    if (wr_eff && a == wa) return wd;
    return m_mem[a];
  endfunction

  task automatic do_cycle(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                          input logic re, input logic [3:0] ra, input logic [3:0] rb,
                          input logic cr);
    bit wr_eff;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr_a = ra; rd_addr_b = rb; clr_req = cr;
    @(posedge clk);
    if (busy_left > 0) begin
      busy_left--;
      m_v = 1'b0;
    end else begin
      wr_eff = we && !cr && !(R0 && wa == 4'd0);
      m_v = re;
      if (re) begin
        m_a = m_read(ra, wr_eff, wa, wd);
        m_b = m_read(rb, wr_eff, wa, wd);
      end
      if (wr_eff) m_mem[wa] = wd;
      if (cr) begin
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        busy_left = 16;
      end
    end
    #1;
  endtask

  task automatic idle_cycle();
    do_cycle(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [3:0]  ra, rb;
    logic [31:0] ea, eb;
    logic        ev;
  } vec_t;

  vec_t tbl [9];
  int   bcnt;
  logic [31:0] r0_exp;

  initial begin
    r0_exp = R0 ? 32'h0 : 32'hFFFF_FFFF;
    tbl[0] = '{1'b0, 4'd0, 32'h0,         1'b1, 4'd3,  4'd15, 32'h0,         32'h0,         1'b1};
    tbl[1] = '{1'b1, 4'd5, 32'hDEADBEEF,  1'b0, 4'd0,  4'd0,  32'h0,         32'h0,         1'b0};
    tbl[2] = '{1'b0, 4'd0, 32'h0,         1'b1, 4'd5,  4'd3,  32'hDEADBEEF,  32'h0,         1'b1};
    tbl[3] = '{1'b1, 4'd7, 32'h12345678,  1'b1, 4'd7,  4'd7,  32'h12345678,  32'h12345678,  1'b1};
    tbl[4] = '{1'b0, 4'd0, 32'h0,         1'b0, 4'd1,  4'd2,  32'h12345678,  32'h12345678,  1'b0};
    tbl[5] = '{1'b0, 4'd0, 32'h0,         1'b1, 4'd5,  4'd7,  32'hDEADBEEF,  32'h12345678,  1'b1};
    tbl[6] = '{1'b0, 4'd0, 32'h0,         1'b1, 4'd7,  4'd5,  32'h12345678,  32'hDEADBEEF,  1'b1};
    tbl[7] = '{1'b1, 4'd0, 32'hFFFFFFFF,  1'b1, 4'd0,  4'd0,  r0_exp,        r0_exp,        1'b1};
    tbl[8] = '{1'b0, 4'd0, 32'h0,         1'b1, 4'd0,  4'd5,  r0_exp,        32'hDEADBEEF,  1'b1};

    model_reset();
    #12;
    chk("reset_rd_a", rd_data_a, 32'h0);
    chk("reset_rd_b", rd_data_b, 32'h0);
    chk("reset_valid", {31'b0, rd_valid}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    clr = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      do_cycle(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra, tbl[i].rb, 1'b0);
      chk("tbl_rd_a", rd_data_a, tbl[i].ea);
      chk("tbl_rd_b", rd_data_b, tbl[i].eb);
      chk("tbl_valid", {31'b0, rd_valid}, {31'b0, tbl[i].ev});
      chk("tbl_busy", {31'b0, busy}, 32'h0);
    end

    // Fill, then clear with a simultaneous read (pre-clear data) and write (dropped)
    for (int i = 0; i < 16; i++) do_cycle(1'b1, 4'(i), 32'h1000 + i, 1'b0, 4'd0, 4'd0, 1'b0);
    do_cycle(1'b1, 4'd2, 32'h5555, 1'b1, 4'd4, 4'd2, 1'b1);
    chk("clr_rd_pre_a", rd_data_a, R0 ? 32'h1004 : 32'h1004);
    chk("clr_rd_pre_b", rd_data_b, 32'h1002);
    chk("clr_rd_valid", {31'b0, rd_valid}, 32'h1);
    bcnt = 0;
    while (busy && bcnt < 40) begin
      bcnt++;
      do_cycle(1'b1, 4'd2, 32'hAAAA, 1'b1, 4'd2, 4'd2, 1'b1);
      if (busy) chk("busy_no_valid", {31'b0, rd_valid}, 32'h0);
    end
    chk("busy_len", bcnt, 32'd16);
    for (int i = 0; i < 16; i++) begin
      do_cycle(1'b0, 4'd0, 32'h0, 1'b1, 4'(i), 4'(15 - i), 1'b0);
      chk("post_clr_a", rd_data_a, 32'h0);
      chk("post_clr_b", rd_data_b, 32'h0);
    end

    // Reset in the middle of a clear
    do_cycle(1'b1, 4'd9, 32'hCAFE0009, 1'b0, 4'd0, 4'd0, 1'b0);
    do_cycle(1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 4'd9, 1'b0);
    chk("pre_rst_a", rd_data_a, 32'hCAFE0009);
    do_cycle(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 5; i++) idle_cycle();
    chk("mid_busy", {31'b0, busy}, 32'h1);
    #2 clr = 1'b0;
    #1;
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    chk("rst_mid_a", rd_data_a, 32'h0);
    chk("rst_mid_b", rd_data_b, 32'h0);
    chk("rst_mid_valid", {31'b0, rd_valid}, 32'h0);
    model_reset();
    @(negedge clk) clr = 1'b1;
    @(posedge clk); #1;
    do_cycle(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 1'b1);
    bcnt = 0;
    while (busy && bcnt < 40) begin
      bcnt++;
      idle_cycle();
    end
    chk("restart_busy_len", bcnt, 32'd16);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      do_cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 39) == 0));
      chk("rnd_rd_a", rd_data_a, m_a);
      chk("rnd_rd_b", rd_data_b, m_b);
      chk("rnd_valid", {31'b0, rd_valid}, {31'b0, m_v});
      chk("rnd_busy", {31'b0, busy}, {31'b0, busy_left > 0});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised register file that generalises the existing 16x32 single-write, dual-read register block.
- Configurable width and depth.
- One write port and two read ports.
- Read outputs are registered, with a valid strobe.
- Write-to-read bypass on the same cycle.
- Hardware bulk-clear sequencer with a busy flag.
Sits in the datapath between the decode stage (supplies addresses) and the ALU operand latches.

Parameters:
DATA_W, 32, bit width of each register.
ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries (localparam, not overridable).

Ports:
clk  in  1  system clock, all state updates on rising edge.
clr  in  1  reset, asynchronous, active-low; clears all state immediately on falling edge.
wr_en  in  1  write strobe.
wr_addr  in  ADDR_W  write address.
wr_data  in  DATA_W  write data.
rd_en  in  1  read request for both read ports.
rd_addr_a  in  ADDR_W  read port A address.
rd_addr_b  in  ADDR_W  read port B address.
rd_data_a  out  DATA_W  registered read data, port A.
rd_data_b  out  DATA_W  registered read data, port B.
rd_valid  out  1  high for one cycle when rd_data_a/b carry a new result.
clr_req  in  1  request synchronous bulk clear of all entries.
busy  out  1  high while the clear sequencer runs.

Behaviour:
Reset (clr low, asynchronous):
- All DEPTH entries = 0.
- rd_data_a = rd_data_b = 0.
- rd_valid = 0, busy = 0.
- FSM = IDLE, clear pointer = 0.

Write:
- In IDLE, when wr_en=1 at rising edge N, mem[wr_addr] <= wr_data at edge N.
- The new value is visible to reads issued at N+1 and later.

Read:
- rd_en=1 at edge N -> rd_data_a/b updated at edge N; rd_valid=1 during cycle N+1 only. Latency is 1 cycle.
- With rd_en=0, rd_data_a/b hold their last value and rd_valid=0.
- Back-to-back rd_en produces rd_valid high on consecutive cycles.

Bypass:
- If wr_en=1 and rd_en=1 in the same cycle and rd_addr_x == wr_addr, port x returns wr_data (new value), not the stale entry.
- Applies independently per port; both ports may bypass at once.

Clear FSM, states IDLE and CLEARING:
- IDLE --clr_req=1--> CLEARING. Pointer = 0; busy=1 from the next cycle.
- CLEARING: each cycle mem[ptr] <= 0, ptr++. After the cycle that writes entry DEPTH-1, go to IDLE; busy drops in the following cycle.
- Exactly DEPTH cycles have busy=1.
- In CLEARING, wr_en, rd_en and clr_req are ignored: no write, rd_valid stays 0, no restart.

Simultaneous events in IDLE:
- clr_req with wr_en: clear wins, the write is dropped.
- clr_req with rd_en: the read is serviced and returns pre-clear data, rd_valid=1.

Reset mid-clear: asynchronous reset overrides; FSM returns to IDLE and busy=0 immediately.

Address range: DEPTH=2**ADDR_W, so every address is valid; the pointer wraps are unreachable because the FSM exits at DEPTH-1.

Optional Feature:
REGFILE_R0_ZERO_EN
- Defined: entry 0 is hardwired zero. Writes to address 0 are discarded. Reads of address 0 return 0, including under bypass. The clear sequencer still runs DEPTH cycles.
- Undefined: entry 0 is an ordinary register.

Decomposition:
Package regfile_pkg holds:
- typedef enum for rf_state_t {IDLE, CLEARING}.
- Default constants RF_DATA_W=32, RF_ADDR_W=4.

One sub-module, regfile_clear_seq:
- Contains the FSM, pointer and busy.
- Outputs clear_we and clear_addr to the storage array.
- The top level owns the storage array, read registers and bypass mux.

Test Plan:
- Reset then rd_en with rd_addr_a=3, rd_addr_b=15 -> next cycle rd_valid=1, rd_data_a=0, rd_data_b=0.
- Write 0xDEADBEEF to addr 5, next cycle rd_en with rd_addr_a=5 -> rd_data_a=0xDEADBEEF one cycle later, rd_valid single pulse.
- Same cycle: wr_en addr 7 data 0x12345678, rd_en rd_addr_a=7, rd_addr_b=7 -> both outputs 0x12345678 next cycle.
- Fill all 16 entries with nonzero values, pulse clr_req -> busy high for exactly 16 cycles; wr_en to addr 2 during busy is ignored; afterwards all reads return 0.
- Pulse clr_req, drop clr low after 5 busy cycles -> busy=0 immediately, all outputs 0, next clr_req restarts at entry 0.
- With REGFILE_R0_ZERO_EN: write 0xFFFFFFFF to addr 0 with simultaneous read of addr 0 -> rd_data_a=0; a later read of addr 0 also returns 0.
